// File: rtl/sm83_pkg.sv
// Shared SM83 front-end types: assembler states, instruction payload and
// the opcode length decode used by the byte assembler.
package sm83_pkg;

    localparam int unsigned OPC_W = 8;
    localparam int unsigned IMM_W = 16;
    localparam int unsigned LEN_W = 2;

    typedef logic [OPC_W-1:0] opcode8_t;

    localparam opcode8_t OP_PREFIX_CB = 8'hCB;

    typedef enum logic [1:0] {
        S_OPC    = 2'd0,
        S_CB     = 2'd1,
        S_IMM_LO = 2'd2,
        S_IMM_HI = 2'd3
    } asm_state_t;

    typedef struct packed {
        opcode8_t          opcode;
        logic              is_cb;
        logic [IMM_W-1:0]  imm;
        logic [LEN_W-1:0]  len;
    } instr_t;

    // Total byte count of an instruction given its first byte; CB counts as 2.
    function automatic logic [LEN_W-1:0] instr_len(input opcode8_t op);
        logic [LEN_W-1:0] len;
        len = 2'd1;
        if ((op[7:6] == 2'b00 || op[7:6] == 2'b11) && op[2:0] == 3'b110) begin
            len = 2'd2;
        end
        case (op)
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hE0, 8'hF0, 8'hE8, 8'hF8, 8'hCB:
                len = 2'd2;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
            8'hEA, 8'hFA:
                len = 2'd3;
            default: ;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/decode_queue_byte_fifo.sv
// Plain synchronous byte FIFO with occupancy count and synchronous clear.
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_en;
    logic             pop_en;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign push_en = push & ~full & ~clear;
    assign pop_en  = pop & ~empty & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-decode byte queue: buffers fetched bytes and assembles whole SM83
// instructions (opcode, CB second byte, immediates) tagged with their PC.
module decode_queue
    import sm83_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    input  logic              i_flush,
    input  logic [PC_W-1:0]   i_flush_pc,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [7:0]        o_opcode,
    output logic              o_is_cb,
    output logic [15:0]       o_imm,
    output logic [1:0]        o_len,
    output logic [PC_W-1:0]   o_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    opcode8_t       head;
    logic           push_c;
    logic           pop_c;

    asm_state_t     state;
    asm_state_t     state_nxt;
    opcode8_t       lat_op;
    logic [1:0]     lat_len;
    logic [7:0]     lat_lo;
    logic [PC_W-1:0] start_pc;
    logic           is_final_c;
    instr_t         ld_c;
    instr_t         instr_q;
    logic           valid_q;
    logic [PC_W-1:0] pc_q;

    assign o_byte_ready = (fifo_count < CW'(DEPTH));
    assign push_c       = i_byte_valid & ~fifo_full & ~i_flush;

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (i_flush),
        .push  (push_c),
        .din   (i_byte),
        .pop   (pop_c),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Classify the head byte and build the payload it would complete.
    always_comb begin
        state_nxt  = state;
        is_final_c = 1'b0;
        ld_c       = '0;
        case (state)
            S_OPC: begin
                if (head == OP_PREFIX_CB) begin
                    state_nxt = S_CB;
                end else if (instr_len(head) == 2'd1) begin
                    is_final_c  = 1'b1;
                    ld_c.opcode = head;
                    ld_c.len    = 2'd1;
                end else begin
                    state_nxt = S_IMM_LO;
                end
            end
            S_CB: begin
                is_final_c  = 1'b1;
                ld_c.opcode = head;
                ld_c.is_cb  = 1'b1;
                ld_c.len    = 2'd2;
                state_nxt   = S_OPC;
            end
            S_IMM_LO: begin
                if (lat_len == 2'd2) begin
                    is_final_c  = 1'b1;
                    ld_c.opcode = lat_op;
                    ld_c.imm    = {8'h00, head};
                    ld_c.len    = 2'd2;
                    state_nxt   = S_OPC;
                end else begin
                    state_nxt = S_IMM_HI;
                end
            end
            S_IMM_HI: begin
                is_final_c  = 1'b1;
                ld_c.opcode = lat_op;
                ld_c.imm    = {head, lat_lo};
                ld_c.len    = 2'd3;
                state_nxt   = S_OPC;
            end
            default: state_nxt = S_OPC;
        endcase
        // A final byte may only pop into an empty or draining output slot.
        pop_c = ~fifo_empty & ~i_flush & (~is_final_c | ~valid_q | i_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_OPC;
            lat_op   <= '0;
            lat_len  <= '0;
            lat_lo   <= '0;
            start_pc <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_q     <= RESET_PC;
        end else if (i_flush) begin
            state    <= S_OPC;
            lat_op   <= '0;
            lat_len  <= '0;
            lat_lo   <= '0;
            start_pc <= i_flush_pc;
            valid_q  <= 1'b0;
        end else begin
            if (pop_c) begin
                state <= state_nxt;
                if (state == S_OPC) begin
                    lat_op  <= head;
                    lat_len <= instr_len(head);
                end
                if (state == S_IMM_LO) lat_lo <= head;
            end
            if (pop_c && is_final_c) begin
                valid_q  <= 1'b1;
                instr_q  <= ld_c;
                pc_q     <= start_pc;
                start_pc <= start_pc + PC_W'(ld_c.len);
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_valid  = valid_q;
    assign o_opcode = instr_q.opcode;
    assign o_is_cb  = instr_q.is_cb;
    assign o_imm    = instr_q.imm;
    assign o_len    = instr_q.len;
    assign o_pc     = pc_q;

endmodule
